// File: rtl/uart_boot_loader.sv
// uart_boot_loader: APB master that polls a UART receiver, parses a framed
// boot image (MAGIC, addr, len, payload, checksum), streams the payload into
// memory as 32-bit word writes and answers the host with a one-byte ack.
module uart_boot_loader #(
  parameter logic [7:0]  MAGIC   = 8'hA5,
  parameter logic [7:0]  ACK_OK  = 8'h4B,
  parameter logic [7:0]  ACK_ERR = 8'h45,
  parameter logic [31:0] MAX_LEN = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] boot_addr,
  output logic [3:0]  apb_PADDR,
  output logic        apb_PSEL,
  output logic        apb_PENABLE,
  output logic        apb_PWRITE,
  output logic [31:0] apb_PWDATA,
  input  logic        apb_PREADY,
  input  logic [31:0] apb_PRDATA,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_valid,
  input  logic        mem_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_HUNT, S_ADDR, S_LEN, S_DATA, S_FLUSH,
    S_SUM, S_CLRERR, S_ACK, S_ACKW, S_DONE
  } state_t;

  // SETUP -> ACCESS (until PREADY) -> GAP (bus idle) -> SETUP ...
  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_GAP} phase_t;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] load_addr_q, load_addr_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [29:0] word_q, word_d;
  logic [31:0] buf_q, buf_d;
  logic [3:0]  strb_q, strb_d;
  logic [7:0]  sum_q, sum_d;
  logic        err_q, err_d;
  logic        error_q, error_d;
  logic [31:0] boot_addr_q, boot_addr_d;

  logic        apb_state;
  logic        xfer_done;
  logic        rx_valid;
  logic        rx_fault;
  logic [7:0]  rx_byte;
  logic [31:0] len_full;
  logic [1:0]  lane;
  logic        unused_prdata;

  assign apb_state = (state_q == S_HUNT) || (state_q == S_ADDR) || (state_q == S_LEN) ||
                     (state_q == S_DATA) || (state_q == S_SUM) || (state_q == S_CLRERR) ||
                     (state_q == S_ACK) || (state_q == S_ACKW);
  assign xfer_done = apb_PENABLE && apb_PREADY;
  assign rx_byte   = apb_PRDATA[7:0];
  // A completed receiver read either yields a byte, a UART error, or nothing.
  assign rx_valid  = xfer_done && !apb_PRDATA[31] && !apb_PRDATA[9];
  assign rx_fault  = xfer_done && !apb_PRDATA[31] &&  apb_PRDATA[9];
  assign lane      = cur_addr_q[1:0];
  assign unused_prdata = ^{apb_PRDATA[30:10], apb_PRDATA[8]};

  assign busy      = apb_state || (state_q == S_FLUSH);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign boot_addr = boot_addr_q;

  assign apb_PSEL    = apb_state && (phase_q != PH_GAP);
  assign apb_PENABLE = apb_state && (phase_q == PH_ACCESS);
  assign apb_PWRITE  = apb_PSEL && ((state_q == S_CLRERR) || (state_q == S_ACKW));
  assign apb_PADDR   = (apb_PSEL && ((state_q == S_ACK) || (state_q == S_ACKW))) ? 4'h4 : 4'h0;
  assign apb_PWDATA  = (apb_PSEL && (state_q == S_ACKW)) ?
                       {24'h0, (err_q ? ACK_ERR : ACK_OK)} : 32'h0;

  assign mem_valid = (state_q == S_FLUSH);
  assign mem_addr  = mem_valid ? {word_q, 2'b00} : 32'h0;
  assign mem_wdata = mem_valid ? buf_q : 32'h0;
  assign mem_wstrb = mem_valid ? strb_q : 4'h0;

  // Next-state logic: APB phase sequencing plus frame parsing.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    load_addr_d = load_addr_q;
    len_d       = len_q;
    cur_addr_d  = cur_addr_q;
    word_d      = word_q;
    buf_d       = buf_q;
    strb_d      = strb_q;
    sum_d       = sum_q;
    err_d       = err_q;
    error_d     = error_q;
    boot_addr_d = boot_addr_q;
    len_full    = {rx_byte, len_q[23:0]};

    if (apb_state) begin
      case (phase_q)
        PH_SETUP:  phase_d = PH_ACCESS;
        PH_ACCESS: if (apb_PREADY) phase_d = PH_GAP;
        default:   phase_d = PH_SETUP;
      endcase
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HUNT;
          phase_d = PH_SETUP;
          cnt_d   = 2'd0;
          sum_d   = 8'h0;
          buf_d   = 32'h0;
          strb_d  = 4'h0;
          err_d   = 1'b0;
        end
      end
      S_HUNT: begin
        if (rx_fault) state_d = S_CLRERR;
        else if (rx_valid && (rx_byte == MAGIC)) begin
          state_d = S_ADDR;
          cnt_d   = 2'd0;
        end
      end
      S_ADDR: begin
        if (rx_fault) state_d = S_CLRERR;
        else if (rx_valid) begin
          load_addr_d[{cnt_q, 3'b000} +: 8] = rx_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cur_addr_d = {rx_byte, load_addr_q[23:0]};
            state_d    = S_LEN;
          end
        end
      end
      S_LEN: begin
        if (rx_fault) state_d = S_CLRERR;
        else if (rx_valid) begin
          len_d[{cnt_q, 3'b000} +: 8] = rx_byte;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (len_full > MAX_LEN) begin
              err_d   = 1'b1;
              state_d = S_ACK;
            end else if (len_full == 32'h0) begin
              state_d = S_SUM;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_fault) state_d = S_CLRERR;
        else if (rx_valid) begin
          buf_d[{lane, 3'b000} +: 8] = rx_byte;
          strb_d[lane] = 1'b1;
          sum_d        = sum_q + rx_byte;
          word_d       = cur_addr_q[31:2];
          cur_addr_d   = cur_addr_q + 32'd1;
          len_d        = len_q - 32'd1;
          if ((lane == 2'd3) || (len_q == 32'd1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (mem_ready) begin
          buf_d   = 32'h0;
          strb_d  = 4'h0;
          state_d = (len_q == 32'h0) ? S_SUM : S_DATA;
        end
      end
      S_SUM: begin
        if (rx_fault) state_d = S_CLRERR;
        else if (rx_valid) begin
          if (rx_byte != sum_q) err_d = 1'b1;
          state_d = S_ACK;
        end
      end
      S_CLRERR: begin
        if (xfer_done) begin
          err_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (xfer_done && !apb_PRDATA[31]) state_d = S_ACKW;
      end
      S_ACKW: begin
        if (xfer_done) begin
          error_d = err_q;
          if (!err_q) boot_addr_d = load_addr_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      phase_q     <= PH_SETUP;
      cnt_q       <= 2'd0;
      load_addr_q <= 32'h0;
      len_q       <= 32'h0;
      cur_addr_q  <= 32'h0;
      word_q      <= 30'h0;
      buf_q       <= 32'h0;
      strb_q      <= 4'h0;
      sum_q       <= 8'h0;
      err_q       <= 1'b0;
      error_q     <= 1'b0;
      boot_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      load_addr_q <= load_addr_d;
      len_q       <= len_d;
      cur_addr_q  <= cur_addr_d;
      word_q      <= word_d;
      buf_q       <= buf_d;
      strb_q      <= strb_d;
      sum_q       <= sum_d;
      err_q       <= err_d;
      error_q     <= error_d;
      boot_addr_q <= boot_addr_d;
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames against a small UART/APB and memory model.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [31:0] boot_addr;
  logic [3:0]  apb_PADDR;
  logic        apb_PSEL, apb_PENABLE, apb_PWRITE;
  logic [31:0] apb_PWDATA;
  logic        apb_PREADY;
  logic [31:0] apb_PRDATA;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_valid;
  logic        mem_ready;

  always #5 clk = ~clk;

  uart_boot_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .error(error), .boot_addr(boot_addr),
    .apb_PADDR(apb_PADDR), .apb_PSEL(apb_PSEL), .apb_PENABLE(apb_PENABLE),
    .apb_PWRITE(apb_PWRITE), .apb_PWDATA(apb_PWDATA), .apb_PREADY(apb_PREADY),
    .apb_PRDATA(apb_PRDATA),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_valid(mem_valid), .mem_ready(mem_ready)
  );

  int checks = 0;
  int failures = 0;

  // Receiver script: each entry is the PRDATA returned by one receiver read.
  logic [31:0] rx_mem [0:1023];
  int rd_ptr = 0;
  int wr_ptr = 0;
  int gap = 0;

  int tx_reads = 0, tx_full_until = 0, tx_cnt = 0;
  int clr_cnt = 0;
  int mem_stall = 0, mwait = 0;
  int apb_slow = 0, acc_wait = 0;
  int mw_cnt = 0, viol = 0;
  logic [7:0]  tx_last = 8'h0;
  logic [31:0] clr_last = 32'hFFFF_FFFF;
  logic [31:0] mw_addr [0:63];
  logic [31:0] mw_data [0:63];
  logic [3:0]  mw_strb [0:63];
  logic prev_psel = 1'b0, prev_pen = 1'b0;

  assign apb_PREADY = apb_PSEL && apb_PENABLE && (acc_wait >= apb_slow);
  assign mem_ready  = mem_valid && (mwait >= mem_stall);

  always_comb begin
    if (apb_PADDR == 4'h4) apb_PRDATA = (tx_reads < tx_full_until) ? 32'h8000_0000 : 32'h0;
    else if (rd_ptr < wr_ptr) apb_PRDATA = rx_mem[rd_ptr[9:0]];
    else apb_PRDATA = 32'h8000_0000;
  end

  // UART, memory and protocol-monitor model.
  always @(posedge clk) begin
    prev_psel <= apb_PSEL;
    prev_pen  <= apb_PENABLE;
    if ((apb_PENABLE && !apb_PSEL) ||
        (apb_PSEL && apb_PENABLE && !prev_psel) ||
        (apb_PSEL && !apb_PENABLE && prev_psel))
      viol <= viol + 1;
    if (apb_PSEL && apb_PENABLE && apb_PREADY) begin
      acc_wait <= 0;
      if (apb_PWRITE) begin
        if (apb_PADDR == 4'h4) begin
          tx_cnt  <= tx_cnt + 1;
          tx_last <= apb_PWDATA[7:0];
        end else begin
          clr_cnt  <= clr_cnt + 1;
          clr_last <= apb_PWDATA;
        end
      end else if (apb_PADDR == 4'h4) begin
        tx_reads <= tx_reads + 1;
      end else if (rd_ptr < wr_ptr) begin
        rd_ptr <= rd_ptr + 1;
      end
    end else if (apb_PSEL && apb_PENABLE) begin
      acc_wait <= acc_wait + 1;
    end else begin
      acc_wait <= 0;
    end
    if (mem_valid && mem_ready) begin
      if (mw_cnt < 64) begin
        mw_addr[mw_cnt[5:0]] <= mem_addr;
        mw_data[mw_cnt[5:0]] <= mem_wdata;
        mw_strb[mw_cnt[5:0]] <= mem_wstrb;
      end
      mw_cnt <= mw_cnt + 1;
      mwait  <= 0;
    end else if (mem_valid) begin
      mwait <= mwait + 1;
    end else begin
      mwait <= 0;
    end
  end

  task automatic push(input logic [31:0] v);
    rx_mem[wr_ptr[9:0]] = v;
    wr_ptr++;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < gap; i++) push(32'h8000_0000);
    push({24'h0, b});
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8]);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    int n;
    n = 0;
    while (!done && n < 8000) begin
      @(negedge clk);
      n++;
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, error} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {busy, done, error}); end
    checks++; if (boot_addr !== 32'h0) begin failures++; $display("FAIL reset_boot_addr got=%h exp=00000000", boot_addr); end
    checks++; if ({apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PADDR} !== 7'h0) begin failures++; $display("FAIL reset_apb_ctrl got=%b exp=0000000", {apb_PSEL, apb_PENABLE, apb_PWRITE, apb_PADDR}); end
    checks++; if ({mem_valid, mem_wstrb, mem_addr, mem_wdata, apb_PWDATA} !== 101'h0) begin failures++; $display("FAIL reset_mem_out got valid=%b addr=%h exp=0", mem_valid, mem_addr); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({busy, apb_PSEL} !== 2'b00) begin failures++; $display("FAIL idle_no_activity got=%b exp=00", {busy, apb_PSEL}); end
    $display("test_reset done");
  endtask

  task automatic test_aligned();
    int mb, tb_;
    bit to;
    logic [31:0] ea [0:1];
    logic [31:0] ed [0:1];
    mb = mw_cnt; tb_ = tx_cnt;
    ea = '{32'h1000, 32'h1004};
    ed = '{32'h0403_0201, 32'h0807_0605};
    push_byte(8'hA5); push_word(32'h1000); push_word(32'd8);
    for (int i = 1; i <= 8; i++) push_byte(i[7:0]);
    push_byte(8'h24);
    do_start();
    checks++; if ({busy, done} !== 2'b10) begin failures++; $display("FAIL aligned_busy got=%b exp=10", {busy, done}); end
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL aligned_timeout got=busy exp=done"); end
    checks++; if (mw_cnt - mb !== 2) begin failures++; $display("FAIL aligned_wr_count got=%0d exp=2", mw_cnt - mb); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mw_addr[mb+i], mw_data[mb+i], mw_strb[mb+i]} !== {ea[i], ed[i], 4'hF}) begin
        failures++; $display("FAIL aligned_wr%0d got=%h/%h/%h exp=%h/%h/f", i, mw_addr[mb+i], mw_data[mb+i], mw_strb[mb+i], ea[i], ed[i]);
      end
    end
    checks++; if ((tx_cnt - tb_ !== 1) || (tx_last !== 8'h4B)) begin failures++; $display("FAIL aligned_ack got=%h n=%0d exp=4b n=1", tx_last, tx_cnt - tb_); end
    checks++; if ({busy, done, error} !== 3'b010) begin failures++; $display("FAIL aligned_status got=%b exp=010", {busy, done, error}); end
    checks++; if (boot_addr !== 32'h1000) begin failures++; $display("FAIL aligned_boot_addr got=%h exp=00001000", boot_addr); end
    checks++; if (rd_ptr !== wr_ptr) begin failures++; $display("FAIL aligned_rx_consumed got=%0d exp=%0d", rd_ptr, wr_ptr); end
    $display("test_aligned writes=%0d ack=%h boot_addr=%h", mw_cnt - mb, tx_last, boot_addr);
  endtask

  task automatic test_unaligned();
    int mb;
    bit to;
    mb = mw_cnt;
    push_byte(8'hA5); push_word(32'h1003); push_word(32'd3);
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC); push_byte(8'h31);
    do_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL unaligned_timeout got=busy exp=done"); end
    checks++; if (mw_cnt - mb !== 2) begin failures++; $display("FAIL unaligned_wr_count got=%0d exp=2", mw_cnt - mb); end
    checks++; if ({mw_addr[mb], mw_data[mb], mw_strb[mb]} !== {32'h1000, 32'hAA00_0000, 4'h8}) begin failures++; $display("FAIL unaligned_wr0 got=%h/%h/%h exp=00001000/aa000000/8", mw_addr[mb], mw_data[mb], mw_strb[mb]); end
    checks++; if ({mw_addr[mb+1], mw_data[mb+1], mw_strb[mb+1]} !== {32'h1004, 32'h0000_CCBB, 4'h3}) begin failures++; $display("FAIL unaligned_wr1 got=%h/%h/%h exp=00001004/0000ccbb/3", mw_addr[mb+1], mw_data[mb+1], mw_strb[mb+1]); end
    checks++; if ({tx_last, error, boot_addr} !== {8'h4B, 1'b0, 32'h1003}) begin failures++; $display("FAIL unaligned_result got=%h/%b/%h exp=4b/0/00001003", tx_last, error, boot_addr); end
    $display("test_unaligned writes=%0d ack=%h boot_addr=%h", mw_cnt - mb, tx_last, boot_addr);
  endtask

  task automatic test_bad_sum();
    int mb;
    bit to;
    mb = mw_cnt;
    push_byte(8'hA5); push_word(32'h1000); push_word(32'd8);
    for (int i = 1; i <= 8; i++) push_byte(i[7:0]);
    push_byte(8'h25);
    do_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL badsum_timeout got=busy exp=done"); end
    checks++; if (mw_cnt - mb !== 2) begin failures++; $display("FAIL badsum_wr_count got=%0d exp=2", mw_cnt - mb); end
    checks++; if ({tx_last, done, error} !== {8'h45, 1'b1, 1'b1}) begin failures++; $display("FAIL badsum_result got=%h/%b/%b exp=45/1/1", tx_last, done, error); end
    checks++; if (boot_addr !== 32'h1003) begin failures++; $display("FAIL badsum_boot_addr got=%h exp=00001003", boot_addr); end
    $display("test_bad_sum ack=%h error=%b", tx_last, error);
  endtask

  task automatic test_noise_backpressure();
    int mb, tr, vb;
    bit to;
    mb = mw_cnt; tr = tx_reads; vb = viol;
    gap = 5; apb_slow = 1; mem_stall = 4; tx_full_until = tx_reads + 3;
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h13);
    push_byte(8'hA5); push_word(32'h2000); push_word(32'd8);
    for (int i = 1; i <= 8; i++) push_byte(8'(i * 16));
    push_byte(8'h40);
    do_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL noise_timeout got=busy exp=done"); end
    checks++; if (mw_cnt - mb !== 2) begin failures++; $display("FAIL noise_wr_count got=%0d exp=2", mw_cnt - mb); end
    checks++; if ({mw_addr[mb], mw_data[mb], mw_strb[mb]} !== {32'h2000, 32'h4030_2010, 4'hF}) begin failures++; $display("FAIL noise_wr0 got=%h/%h/%h exp=00002000/40302010/f", mw_addr[mb], mw_data[mb], mw_strb[mb]); end
    checks++; if ({mw_addr[mb+1], mw_data[mb+1], mw_strb[mb+1]} !== {32'h2004, 32'h8070_6050, 4'hF}) begin failures++; $display("FAIL noise_wr1 got=%h/%h/%h exp=00002004/80706050/f", mw_addr[mb+1], mw_data[mb+1], mw_strb[mb+1]); end
    checks++; if (tx_reads - tr !== 4) begin failures++; $display("FAIL noise_tx_polls got=%0d exp=4", tx_reads - tr); end
    checks++; if ({tx_last, error, boot_addr} !== {8'h4B, 1'b0, 32'h2000}) begin failures++; $display("FAIL noise_result got=%h/%b/%h exp=4b/0/00002000", tx_last, error, boot_addr); end
    checks++; if (rd_ptr !== wr_ptr) begin failures++; $display("FAIL noise_rx_consumed got=%0d exp=%0d", rd_ptr, wr_ptr); end
    checks++; if (viol - vb !== 0) begin failures++; $display("FAIL noise_apb_protocol got=%0d exp=0", viol - vb); end
    gap = 0; apb_slow = 0; mem_stall = 0;
    $display("test_noise_backpressure writes=%0d tx_polls=%0d ack=%h", mw_cnt - mb, tx_reads - tr, tx_last);
  endtask

  task automatic test_rx_err_and_len();
    int mb, cb;
    bit to;
    mb = mw_cnt; cb = clr_cnt;
    push_byte(8'hA5); push_word(32'h3000); push_byte(8'h08); push(32'h0000_0200);
    do_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL rxerr_timeout got=busy exp=done"); end
    checks++; if ((clr_cnt - cb !== 1) || (clr_last !== 32'h0)) begin failures++; $display("FAIL rxerr_clear got=n%0d/%h exp=n1/00000000", clr_cnt - cb, clr_last); end
    checks++; if ({tx_last, error, boot_addr} !== {8'h45, 1'b1, 32'h2000}) begin failures++; $display("FAIL rxerr_result got=%h/%b/%h exp=45/1/00002000", tx_last, error, boot_addr); end
    checks++; if (mw_cnt - mb !== 0) begin failures++; $display("FAIL rxerr_wr_count got=%0d exp=0", mw_cnt - mb); end
    $display("test_rx_err ack=%h clears=%0d", tx_last, clr_cnt - cb);
    mb = mw_cnt; cb = clr_cnt;
    tx_last = 8'h00;
    push_byte(8'hA5); push_word(32'h4000); push_word(32'h0010_0001);
    do_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL biglen_timeout got=busy exp=done"); end
    checks++; if ({tx_last, error} !== {8'h45, 1'b1}) begin failures++; $display("FAIL biglen_result got=%h/%b exp=45/1", tx_last, error); end
    checks++; if ((mw_cnt - mb !== 0) || (clr_cnt - cb !== 0)) begin failures++; $display("FAIL biglen_side_effects got=wr%0d/clr%0d exp=wr0/clr0", mw_cnt - mb, clr_cnt - cb); end
    checks++; if (rd_ptr !== wr_ptr) begin failures++; $display("FAIL biglen_rx_consumed got=%0d exp=%0d", rd_ptr, wr_ptr); end
    $display("test_len_too_big ack=%h error=%b", tx_last, error);
  endtask

  task automatic test_zero_len_and_wrap();
    int mb;
    bit to;
    mb = mw_cnt;
    push_byte(8'hA5); push_word(32'h5000); push_word(32'd0); push_byte(8'h00);
    do_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL zerolen_timeout got=busy exp=done"); end
    checks++; if ({mw_cnt - mb, tx_last, error, boot_addr} !== {32'd0, 8'h4B, 1'b0, 32'h5000}) begin failures++; $display("FAIL zerolen_result got=wr%0d/%h/%b/%h exp=wr0/4b/0/00005000", mw_cnt - mb, tx_last, error, boot_addr); end
    $display("test_zero_len ack=%h boot_addr=%h", tx_last, boot_addr);
    mb = mw_cnt;
    push_byte(8'hA5); push_word(32'hFFFF_FFFE); push_word(32'd4);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44); push_byte(8'hAA);
    do_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL wrap_timeout got=busy exp=done"); end
    checks++; if ({mw_addr[mb], mw_data[mb], mw_strb[mb]} !== {32'hFFFF_FFFC, 32'h2211_0000, 4'hC}) begin failures++; $display("FAIL wrap_wr0 got=%h/%h/%h exp=fffffffc/22110000/c", mw_addr[mb], mw_data[mb], mw_strb[mb]); end
    checks++; if ({mw_addr[mb+1], mw_data[mb+1], mw_strb[mb+1]} !== {32'h0, 32'h0000_4433, 4'h3}) begin failures++; $display("FAIL wrap_wr1 got=%h/%h/%h exp=00000000/00004433/3", mw_addr[mb+1], mw_data[mb+1], mw_strb[mb+1]); end
    checks++; if ({mw_cnt - mb, tx_last, error} !== {32'd2, 8'h4B, 1'b0}) begin failures++; $display("FAIL wrap_result got=wr%0d/%h/%b exp=wr2/4b/0", mw_cnt - mb, tx_last, error); end
    $display("test_wrap writes=%0d ack=%h", mw_cnt - mb, tx_last);
  endtask

  task automatic test_reset_mid_flush();
    int mb, n;
    bit to;
    mb = mw_cnt;
    mem_stall = 1000;
    push_byte(8'hA5); push_word(32'h6000); push_word(32'd8);
    for (int i = 1; i <= 8; i++) push_byte(i[7:0]);
    push_byte(8'h24);
    do_start();
    n = 0;
    while (!mem_valid && n < 2000) begin @(negedge clk); n++; end
    checks++; if (!mem_valid) begin failures++; $display("FAIL midrst_reach_flush got=%b exp=1", mem_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({mem_valid, apb_PSEL, busy, done} !== 4'b0000) begin failures++; $display("FAIL midrst_outputs got=%b exp=0000", {mem_valid, apb_PSEL, busy, done}); end
    @(negedge clk);
    wr_ptr = rd_ptr;
    mem_stall = 0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({mw_cnt - mb, boot_addr} !== {32'd0, 32'h0}) begin failures++; $display("FAIL midrst_cleared got=wr%0d/%h exp=wr0/00000000", mw_cnt - mb, boot_addr); end
    push_byte(8'hA5); push_word(32'h7000); push_word(32'd8);
    for (int i = 1; i <= 8; i++) push_byte(i[7:0]);
    push_byte(8'h24);
    do_start();
    wait_done(to);
    checks++; if (to) begin failures++; $display("FAIL midrst_reload_timeout got=busy exp=done"); end
    checks++; if ({mw_addr[mb], mw_data[mb], mw_addr[mb+1], mw_data[mb+1]} !== {32'h7000, 32'h0403_0201, 32'h7004, 32'h0807_0605}) begin failures++; $display("FAIL midrst_reload_writes got=%h/%h %h/%h exp=00007000/04030201 00007004/08070605", mw_addr[mb], mw_data[mb], mw_addr[mb+1], mw_data[mb+1]); end
    checks++; if ({tx_last, error, boot_addr} !== {8'h4B, 1'b0, 32'h7000}) begin failures++; $display("FAIL midrst_reload_result got=%h/%b/%h exp=4b/0/00007000", tx_last, error, boot_addr); end
    checks++; if (viol !== 0) begin failures++; $display("FAIL apb_protocol_total got=%0d exp=0", viol); end
    $display("test_reset_mid_flush writes=%0d boot_addr=%h", mw_cnt - mb, boot_addr);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_unaligned();
    test_bad_sum();
    test_noise_backpressure();
    test_rx_err_and_len();
    test_zero_len_and_wrap();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
